// File: rtl/biquad_cascade_scheduler.sv
// Purpose : sequences one shared biquad MAC engine across NUM_BANDS cascaded EQ bands once per I2S frame.
// Latency : sample_valid follows frame_start by 1 + sum(band: 2 + engine latency, or 2 if bypassed) + 1 clk.
// Backpres: waits on eng_done per band; a frame edge arriving while busy is dropped and sets sticky overrun.
//
// Ports: clk/reset (sync, active-high); l_r_clk frame clock (async); sample_in, bypass in;
//        cfg_we/cfg_band/cfg_sel/cfg_data write the shadow coefficient bank, cfg_commit
//        requests a shadow->active copy at the next frame start; eng_* is the start/done
//        handshake plus operands to the MAC engine; sample_out/sample_valid/overrun out.
module biquad_cascade_scheduler #(
    parameter  int NUM_BANDS = 3,
    parameter  int W         = 16,
    localparam int BW        = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 l_r_clk,
    input  logic [W-1:0]         sample_in,
    input  logic [NUM_BANDS-1:0] bypass,
    input  logic                 cfg_we,
    input  logic [BW-1:0]        cfg_band,
    input  logic [2:0]           cfg_sel,
    input  logic [W-1:0]         cfg_data,
    input  logic                 cfg_commit,
    output logic                 eng_start,
    output logic [W-1:0]         eng_x0,
    output logic [W-1:0]         eng_x1,
    output logic [W-1:0]         eng_x2,
    output logic [W-1:0]         eng_y1,
    output logic [W-1:0]         eng_y2,
    output logic [W-1:0]         eng_b0,
    output logic [W-1:0]         eng_b1,
    output logic [W-1:0]         eng_b2,
    output logic [W-1:0]         eng_a1,
    output logic [W-1:0]         eng_a2,
    input  logic                 eng_done,
    input  logic [W-1:0]         eng_y,
    output logic [W-1:0]         sample_out,
    output logic                 sample_valid,
    output logic                 overrun
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_STORE, S_OUT} state_t;

    // One band's coefficients; element index equals cfg_sel: 0=b0 1=b1 2=b2 3=a1 4=a2.
    typedef logic [4:0][W-1:0] coef_t;

    localparam logic [W-1:0] UNITY    = {2'b01, {(W-2){1'b0}}};
    localparam coef_t        PASSTHRU = {{(4*W){1'b0}}, UNITY};

    state_t               state_q, state_d;
    logic [2:0]           lr_sync;
    logic                 frame_start;
    logic [BW-1:0]        k_q;
    logic                 last_band;
    logic [NUM_BANDS-1:0] byp_q;
    logic [W-1:0]         cur_q;
    logic [W-1:0]         result_q;
    logic                 commit_pending;
    logic                 cfg_ok;

    coef_t                shadow [NUM_BANDS];
    coef_t                active [NUM_BANDS];
    logic [W-1:0]         x1_q   [NUM_BANDS];
    logic [W-1:0]         x2_q   [NUM_BANDS];
    logic [W-1:0]         y1_q   [NUM_BANDS];
    logic [W-1:0]         y2_q   [NUM_BANDS];

    // lr_sync[1:0] is the two-flop synchronizer; lr_sync[2] is the edge-detect history.
    assign frame_start = lr_sync[1] & ~lr_sync[2];
    assign last_band   = (int'(k_q) == NUM_BANDS - 1);
    assign cfg_ok      = cfg_we && (int'(cfg_band) < NUM_BANDS) && (cfg_sel < 3'd5);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        eng_start = 1'b0;
        eng_x0    = '0;
        eng_x1    = '0;
        eng_x2    = '0;
        eng_y1    = '0;
        eng_y2    = '0;
        eng_b0    = '0;
        eng_b1    = '0;
        eng_b2    = '0;
        eng_a1    = '0;
        eng_a2    = '0;
        case (state_q)
            S_IDLE:  if (frame_start) state_d = S_LOAD;
            S_LOAD: begin
                if (byp_q[k_q]) begin
                    state_d = S_STORE;
                end else begin
                    state_d   = S_WAIT;
                    eng_start = 1'b1;
                end
            end
            S_WAIT:  if (eng_done) state_d = S_STORE;
            S_STORE: state_d = last_band ? S_OUT : S_LOAD;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Operands come straight from registers that do not move until STORE,
        // so they stay stable for the whole engine operation.
        if (eng_start || state_q == S_WAIT) begin
            eng_x0 = cur_q;
            eng_x1 = x1_q[k_q];
            eng_x2 = x2_q[k_q];
            eng_y1 = y1_q[k_q];
            eng_y2 = y2_q[k_q];
            eng_b0 = active[k_q][0];
            eng_b1 = active[k_q][1];
            eng_b2 = active[k_q][2];
            eng_a1 = active[k_q][3];
            eng_a2 = active[k_q][4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lr_sync        <= '0;
            k_q            <= '0;
            byp_q          <= '0;
            cur_q          <= '0;
            result_q       <= '0;
            commit_pending <= 1'b0;
            overrun        <= 1'b0;
            sample_out     <= '0;
            sample_valid   <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                shadow[b] <= PASSTHRU;
                active[b] <= PASSTHRU;
                x1_q[b]   <= '0;
                x2_q[b]   <= '0;
                y1_q[b]   <= '0;
                y2_q[b]   <= '0;
            end
        end else begin
            lr_sync      <= {lr_sync[1:0], l_r_clk};
            sample_valid <= (state_q == S_OUT);

            if (cfg_commit) commit_pending <= 1'b1;
            if (cfg_ok) shadow[cfg_band][cfg_sel] <= cfg_data;
            if (frame_start && state_q != S_IDLE) overrun <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        cur_q <= sample_in;
                        byp_q <= bypass;
                        k_q   <= '0;
                        // A commit in this same cycle still applies to this frame;
                        // the copy reads shadow before any same-cycle cfg write lands.
                        if (commit_pending || cfg_commit) begin
                            for (int b = 0; b < NUM_BANDS; b++) active[b] <= shadow[b];
                            commit_pending <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (byp_q[k_q]) result_q <= cur_q;
                end
                S_WAIT: begin
                    if (eng_done) result_q <= eng_y;
                end
                S_STORE: begin
                    if (!byp_q[k_q]) begin
                        x2_q[k_q] <= x1_q[k_q];
                        x1_q[k_q] <= cur_q;
                        y2_q[k_q] <= y1_q[k_q];
                        y1_q[k_q] <= result_q;
                    end
                    cur_q <= result_q;
                    if (!last_band) k_q <= k_q + BW'(1);
                end
                S_OUT: begin
                    sample_out <= cur_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_cascade_scheduler.sv
// Purpose : randomized and directed checks of biquad_cascade_scheduler against a per-frame cascade model.
// Latency : frames take tens of clk (thousands for the slow-engine overrun case).
// Backpres: a mock MAC engine answers eng_start after a programmable latency.
module tb_biquad_cascade_scheduler;

    localparam int NB = 3;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          l_r_clk;
    logic [W-1:0]  sample_in;
    logic [NB-1:0] bypass;
    logic          cfg_we;
    logic [1:0]    cfg_band;
    logic [2:0]    cfg_sel;
    logic [W-1:0]  cfg_data;
    logic          cfg_commit;
    logic          eng_start;
    logic [W-1:0]  eng_x0, eng_x1, eng_x2, eng_y1, eng_y2;
    logic [W-1:0]  eng_b0, eng_b1, eng_b2, eng_a1, eng_a2;
    logic          eng_done;
    logic [W-1:0]  eng_y;
    logic [W-1:0]  sample_out;
    logic          sample_valid;
    logic          overrun;

    biquad_cascade_scheduler #(.NUM_BANDS(NB), .W(W)) dut (
        .clk(clk), .reset(reset), .l_r_clk(l_r_clk), .sample_in(sample_in), .bypass(bypass),
        .cfg_we(cfg_we), .cfg_band(cfg_band), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .eng_start(eng_start),
        .eng_x0(eng_x0), .eng_x1(eng_x1), .eng_x2(eng_x2), .eng_y1(eng_y1), .eng_y2(eng_y2),
        .eng_b0(eng_b0), .eng_b1(eng_b1), .eng_b2(eng_b2), .eng_a1(eng_a1), .eng_a2(eng_a2),
        .eng_done(eng_done), .eng_y(eng_y),
        .sample_out(sample_out), .sample_valid(sample_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- arithmetic shared by mock engine and reference model ----------------
    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [W-1:0] sat_q14(input longint acc);
        longint r;
        r = acc >>> 14;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    // ---------------- mock MAC engine ----------------
    int           eng_lat = 5;
    bit           mk_busy = 0;
    int           mk_cnt;
    int           starts_seen;
    logic [159:0] mk_ops;

    function automatic logic [159:0] ops_now();
        return {eng_x0, eng_x1, eng_x2, eng_y1, eng_y2, eng_b0, eng_b1, eng_b2, eng_a1, eng_a2};
    endfunction

    function automatic logic [W-1:0] eng_calc(input logic [159:0] o);
        return sat_q14(sx(o[79:64]) * sx(o[159:144]) + sx(o[63:48]) * sx(o[143:128]) +
                       sx(o[47:32]) * sx(o[127:112]) + sx(o[31:16]) * sx(o[111:96]) +
                       sx(o[15:0])  * sx(o[95:80]));
    endfunction

    initial begin
        eng_done = 1'b0;
        eng_y    = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (mk_busy) begin
                mk_cnt--;
                if (mk_cnt == 0) begin
                    check_eq("op_stable", 32'(ops_now() === mk_ops), 32'd1);
                    eng_y    = eng_calc(mk_ops);
                    eng_done = 1'b1;
                    mk_busy  = 0;
                end
            end
            if (eng_start) begin
                check_eq("eng_overlap", 32'(mk_busy), 32'd0);
                mk_ops  = ops_now();
                mk_cnt  = eng_lat;
                mk_busy = 1;
                starts_seen++;
            end
        end
    end

    // ---------------- reference model: one call = one whole frame ----------------
    logic [W-1:0] m_sh  [NB][5];
    logic [W-1:0] m_act [NB][5];
    logic [W-1:0] m_x1[NB], m_x2[NB], m_y1[NB], m_y2[NB];
    bit           m_pending;

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < 5; c++) begin
                m_sh[b][c]  = (c == 0) ? 16'h4000 : 16'h0000;
                m_act[b][c] = m_sh[b][c];
            end
            m_x1[b] = 0; m_x2[b] = 0; m_y1[b] = 0; m_y2[b] = 0;
        end
        m_pending = 0;
    endtask

    task automatic model_write(input int band, input int sel, input logic [W-1:0] d);
        if (band < NB && sel < 5) m_sh[band][sel] = d;
    endtask

    // Expected output, engine starts, and clk edges from l_r_clk rise to visible sample_valid:
    // 2 sync edges, 1 IDLE, per band (2 + L) or 2, 1 OUT.
    task automatic model_frame(input logic [W-1:0] s, input logic [NB-1:0] byp,
                               output logic [W-1:0] y, output int nstart, output int lat);
        logic [W-1:0] cur, r;
        cur = s; nstart = 0; lat = 4;
        if (m_pending) begin
            for (int b = 0; b < NB; b++)
                for (int c = 0; c < 5; c++) m_act[b][c] = m_sh[b][c];
            m_pending = 0;
        end
        for (int b = 0; b < NB; b++) begin
            if (byp[b]) begin
                lat += 2;
            end else begin
                r = sat_q14(sx(m_act[b][0]) * sx(cur)     + sx(m_act[b][1]) * sx(m_x1[b]) +
                            sx(m_act[b][2]) * sx(m_x2[b]) + sx(m_act[b][3]) * sx(m_y1[b]) +
                            sx(m_act[b][4]) * sx(m_y2[b]));
                m_x2[b] = m_x1[b]; m_x1[b] = cur;
                m_y2[b] = m_y1[b]; m_y1[b] = r;
                cur = r;
                nstart++;
                lat += 2 + eng_lat;
            end
        end
        y = cur;
    endtask

    // ---------------- stimulus tasks (all enter and leave #1 after a rising edge) ----------------
    int           cw_band, cw_sel;
    logic [W-1:0] cw_data;

    task automatic do_reset();
        reset = 1; l_r_clk = 0; cfg_we = 0; cfg_commit = 0;
        mk_busy = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        model_reset();
    endtask

    task automatic cfg_write(input int band, input int sel, input logic [W-1:0] d);
        cfg_we = 1; cfg_band = 2'(band); cfg_sel = 3'(sel); cfg_data = d;
        @(posedge clk); #1 cfg_we = 0;
        model_write(band, sel, d);
    endtask

    task automatic commit_req();
        cfg_commit = 1;
        @(posedge clk); #1 cfg_commit = 0;
        m_pending = 1;
    endtask

    // mode 0 plain, 1 write+commit in the frame_start cycle, 2 write+commit mid-frame,
    // 3 second l_r_clk edge while busy.
    task automatic run_frame(input logic [W-1:0] s, input logic [NB-1:0] byp, input int mode);
        logic [W-1:0] exp_y;
        int exp_st, exp_lat, n;
        bit got;
        if (mode == 1) m_pending = 1;
        model_frame(s, byp, exp_y, exp_st, exp_lat);
        if (mode == 1 || mode == 2) model_write(cw_band, cw_sel, cw_data);
        if (mode == 2) m_pending = 1;
        sample_in = s; bypass = byp; starts_seen = 0;
        l_r_clk = 1; n = 0; got = 0;
        while (!got && n < exp_lat + 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 8) l_r_clk = 0;
            if (mode == 3) begin
                if (n == 20) l_r_clk = 1;
                if (n == 30) l_r_clk = 0;
                if (n == 40) check_eq("overrun_set", 32'(overrun), 32'd1);
            end
            // frame_start is seen between edges 2 and 3 after the l_r_clk rise
            if ((mode == 1 && n == 2) || (mode == 2 && n == 10)) begin
                cfg_we = 1; cfg_commit = 1;
                cfg_band = 2'(cw_band); cfg_sel = 3'(cw_sel); cfg_data = cw_data;
            end else begin
                cfg_we = 0; cfg_commit = 0;
            end
            if (sample_valid) got = 1;
        end
        check_eq("frame_timeout", 32'(got), 32'd1);
        check_eq("sample_out", 32'(sample_out), 32'(exp_y));
        check_eq("latency", 32'(n), 32'(exp_lat));
        check_eq("eng_starts", 32'(starts_seen), 32'(exp_st));
        @(posedge clk); #1;
        check_eq("valid_pulse", 32'(sample_valid), 32'd0);
    endtask

    function automatic logic [W-1:0] rand_coef();
        return 16'(int'($urandom_range(0, 8192)) - 4096);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv;
        reset = 1; l_r_clk = 0; sample_in = 0; bypass = 0;
        cfg_we = 0; cfg_band = 0; cfg_sel = 0; cfg_data = 0; cfg_commit = 0;
        cw_band = 0; cw_sel = 0; cw_data = 0;
        do_reset();
        check_eq("rst_sample_out", 32'(sample_out), 32'd0);
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_eng_start", 32'(eng_start), 32'd0);
        check_eq("rst_eng_b0", 32'(eng_b0), 32'd0);
        check_eq("rst_eng_x0", 32'(eng_x0), 32'd0);

        // Passthrough bank, engine latency 5: 0x2000 out, 25 edges after the l_r_clk rise.
        eng_lat = 5;
        repeat (3) run_frame(16'h2000, 3'b000, 0);

        // Band0 b0 = 0.5 committed mid-frame: only visible from the next frame.
        cw_band = 0; cw_sel = 0; cw_data = 16'h2000;
        run_frame(16'h4000, 3'b000, 2);
        run_frame(16'h4000, 3'b000, 0);
        run_frame(16'h0000, 3'b000, 0);

        // Band1 one-pole: impulse gives 0x2000, 0x1000, ...; bypass freezes band1 for a frame.
        do_reset();
        cfg_write(1, 0, 16'h2000);
        cfg_write(1, 3, 16'h2000);
        commit_req();
        run_frame(16'h4000, 3'b000, 0);
        run_frame(16'h0000, 3'b000, 0);
        run_frame(16'h0000, 3'b010, 0);
        run_frame(16'h0000, 3'b000, 0);

        // Out-of-range shadow writes are ignored even after a commit.
        cfg_write(3, 0, 16'h7fff);
        cfg_write(0, 6, 16'h7fff);
        cfg_write(2, 7, 16'h7fff);
        commit_req();
        run_frame(16'h0000, 3'b000, 0);

        // Commit in the frame_start cycle applies now; the same-cycle write does not.
        cfg_write(2, 0, 16'h2000);
        cw_band = 0; cw_sel = 0; cw_data = 16'h1000;
        run_frame(16'h4000, 3'b000, 1);
        run_frame(16'h4000, 3'b000, 0);

        // Randomized frames, coefficients, bypass masks and engine latencies.
        for (int i = 0; i < 24; i++) begin
            eng_lat = $urandom_range(1, 6);
            if ($urandom_range(0, 2) == 0) begin
                for (int j = 0; j < 2; j++)
                    cfg_write($urandom_range(0, 3), $urandom_range(0, 7), rand_coef());
                commit_req();
            end
            cw_band = $urandom_range(0, 3); cw_sel = $urandom_range(0, 7); cw_data = rand_coef();
            run_frame(16'($urandom_range(0, 16'hffff)), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        // Reset in the middle of an engine wait.
        eng_lat = 5;
        sample_in = 16'h1234; bypass = 3'b000; l_r_clk = 1;
        repeat (6) @(posedge clk);
        #1 reset = 1; l_r_clk = 0; mk_busy = 0;
        @(posedge clk); #1;
        check_eq("midrst_eng_start", 32'(eng_start), 32'd0);
        check_eq("midrst_eng_x0", 32'(eng_x0), 32'd0);
        check_eq("midrst_sample_out", 32'(sample_out), 32'd0);
        check_eq("midrst_valid", 32'(sample_valid), 32'd0);
        reset = 0;
        model_reset();
        nv = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (sample_valid) nv++;
        end
        check_eq("midrst_no_valid", 32'(nv), 32'd0);
        // b1 = 1.0 exposes any delay state left behind by the aborted frame.
        cfg_write(0, 1, 16'h4000);
        commit_req();
        run_frame(16'h1000, 3'b000, 0);
        run_frame(16'h0800, 3'b000, 0);

        // Slow engine: second edge while busy sets overrun, which stays until reset.
        eng_lat = 3000;
        run_frame(16'h0400, 3'b000, 3);
        check_eq("overrun_held", 32'(overrun), 32'd1);
        eng_lat = 5;
        run_frame(16'h0200, 3'b000, 0);
        check_eq("overrun_sticky", 32'(overrun), 32'd1);
        do_reset();
        check_eq("overrun_cleared", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/biquad_cascade_scheduler.md
# biquad_cascade_scheduler

Sequences one shared, time-multiplexed biquad MAC engine (iir_time_mux_accum-class datapath with start/done handshake) across NUM_BANDS cascaded EQ bands once per audio frame. Owns per-band delay state, a double-buffered coefficient bank written by the control side, and the frame-to-frame schedule. Sits between the I2S receive path (sample_in, l_r_clk) and the I2S transmit path (sample_out).

## Interface
- NUM_BANDS, 3, cascaded bands, 1..8
- W, 16, sample/coefficient width, Q2.14 signed
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high
- l_r_clk  in  1  I2S frame clock, asynchronous to clk; rising edge = new sample
- sample_in  in  W  input sample, Q2.14
- bypass  in  NUM_BANDS  per-band bypass, sampled at frame start
- cfg_we  in  1  write shadow coefficient
- cfg_band  in  $clog2(NUM_BANDS) (min 1)  target band
- cfg_sel  in  3  0=b0 1=b1 2=b2 3=a1 4=a2; 5..7 ignored
- cfg_data  in  W  coefficient value, Q2.14
- cfg_commit  in  1  request shadow->active copy at next frame start
- eng_start  out  1  one-cycle start pulse to MAC engine
- eng_x0, eng_x1, eng_x2, eng_y1, eng_y2  out  W each  operand samples
- eng_b0, eng_b1, eng_b2, eng_a1, eng_a2  out  W each  active coefficients of current band
- eng_done  in  1  one-cycle completion pulse
- eng_y  in  W  engine result, y = b0·x0+b1·x1+b2·x2+a1·y1+a2·y2, saturated by engine
- sample_out  out  W  cascade output, Q2.14
- sample_valid  out  1  one-cycle pulse when sample_out updates
- overrun  out  1  sticky: frame edge arrived while busy

## Operation
- l_r_clk passes a 2-flop synchronizer; rising edge of synced signal (vs. a third flop) = frame_start, one clk pulse.
- FSM: IDLE, LOAD, WAIT, STORE, OUT.
- IDLE: on frame_start capture sample_in into cur, latch bypass, band index k=0; if commit_pending, copy entire shadow bank to active and clear commit_pending (same cycle); go LOAD.
- LOAD (band k): if bypass[k], go STORE with result=cur, no engine op. Else drive operands x0=cur, x1/x2/y1/y2 = band k state, coefficients = active[k]; pulse eng_start; go WAIT.
- WAIT: hold all eng_* operands stable; on eng_done capture eng_y as result, go STORE. eng_done outside WAIT ignored.
- STORE: for non-bypassed band: x2<=x1, x1<=cur, y2<=y1, y1<=result; bypassed band state held unchanged. cur<=result. If k==NUM_BANDS-1 go OUT, else k<=k+1, go LOAD.
- OUT: sample_out<=cur, sample_valid=1, go IDLE.
- cfg_we writes shadow[cfg_band][cfg_sel] any cycle, any state; cfg_band ≥ NUM_BANDS or cfg_sel ≥ 5 ignored. Active bank only changes in IDLE at frame_start, never mid-frame.
- cfg_commit sets commit_pending; commit asserted in same cycle as frame_start applies to that frame; cfg_we in that same cycle is not included in the copy.
- frame_start while not IDLE: edge dropped, overrun<=1, current frame completes normally. overrun cleared only by reset.

## Timing
- Reset values: all outputs 0; FSM IDLE; all delay state 0; commit_pending 0; overrun 0; active and shadow banks = passthrough (b0=0x4000, others 0).
- frame_start = 3 clk after l_r_clk rising edge (±1 for sync uncertainty).
- Per non-bypassed band: LOAD 1 + engine latency L + STORE 1 cycles; bypassed band: 2 cycles.
- sample_valid occurs 1 + Σ(per-band) + 1 cycles after frame_start; must be < 2083 cycles (48 kHz at 100 MHz).
- eng_start never asserted outside LOAD; at most one outstanding engine op.
- reset asserted mid-frame: FSM to IDLE next edge, no sample_valid for that frame, state cleared.

## Test plan
- Reset, no config; mock engine latency 5; sample_in=0x2000 -> sample_out=0x2000, one sample_valid per frame, latency 3·(7)+2 cycles after frame_start.
- Band0 b0=0x2000 committed, bands1-2 passthrough; impulse 0x4000 then zeros -> outputs 0x2000, 0, 0…; commit not visible before next frame.
- Band1 b0=0x2000,a1=0x2000 -> impulse 0x4000 gives 0x2000, 0x1000, 0x0800…; verify y1/y2/x1/x2 shifts per band.
- bypass=3'b010 with band1 nonzero coefs -> band1 skipped (no eng_start for k=1), band1 state frozen, resumes from held values when bypass clears.
- Mock engine latency 3000 cycles -> overrun=1 after second l_r_clk edge, frame still completes, overrun stays 1 until reset.
- Shadow writes (cfg_band=3, cfg_sel=6) ignored; cfg_commit coincident with frame_start applied to that frame; reset mid-WAIT clears outputs and state.
